bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL set the address width of all address ports.
REQ-002 clk  in  1  SHALL be the clock; all state changes on its rising edge.
REQ-003 reset  in  1  SHALL be the reset: synchronous, active-low.
REQ-004 ireq_valid in 1, ireq_addr in ADDR_W  SHALL form the instruction-fetch request from the core.
REQ-005 iresp_data_ok out 1, iresp_data out 32  SHALL carry the fetch response: a 1-cycle pulse with the 32-bit word.
REQ-006 dreq_valid in 1, dreq_addr in ADDR_W, dreq_size in 3, dreq_strobe in 8, dreq_data in 64  SHALL form the data request; strobe all zero means read.
REQ-007 dresp_data_ok out 1, dresp_data out 64  SHALL carry the data response: a 1-cycle pulse with read data.
REQ-008 creq_valid out 1, creq_is_write out 1, creq_addr out ADDR_W, creq_size out 3, creq_strobe out 8, creq_data out 64  SHALL form the single memory-side request.
REQ-009 cresp_ready in 1, cresp_last in 1, cresp_data in 64  SHALL form the memory-side response: ready = request accepted; last = data valid, single beat.

Function
REQ-010 The FSM SHALL have four states: IDLE, REQ, WAIT, RESP.
REQ-011 IDLE: if any requester is valid, the FSM SHALL grant one, latch its request fields into registers, record the owner, and go to REQ next cycle.
REQ-012 Arbitration when both are valid SHALL be round-robin: a last_owner bit, reset to DBUS, gives priority to the other port; last_owner updates on every grant.
REQ-013 REQ: creq_valid SHALL be 1, with creq_* driven only from latched registers and stable until cresp_ready is sampled 1.
REQ-014 REQ with cresp_ready=1 and cresp_last=0 SHALL go to WAIT; with cresp_ready=1 and cresp_last=1 in the same cycle, it SHALL go directly to RESP.
REQ-015 WAIT: creq_valid SHALL be 0; on cresp_last=1 the FSM SHALL capture cresp_data and go to RESP.
REQ-016 cresp_last outside REQ/WAIT SHALL be ignored.
REQ-017 RESP: exactly one cycle; the owner's data_ok SHALL be 1 and the other port's data_ok 0; the FSM SHALL then return to IDLE.
REQ-018 iresp_data SHALL be the captured data bits [63:32] if latched addr[2]=1, else bits [31:0].
REQ-019 For an ibus grant, creq_is_write SHALL be 0, creq_size 3'b010, and creq_strobe 0.
REQ-020 For a dbus grant, creq_is_write SHALL equal OR of latched strobe, with size, strobe and data passed through as latched.
REQ-021 Requester inputs SHALL be sampled only in IDLE; changes in other states are ignored.
REQ-022 Minimum latency SHALL be 3 cycles from a valid request in IDLE to data_ok, with zero memory wait.
REQ-023 Back-to-back: after RESP, IDLE SHALL re-arbitrate on the following cycle, giving 1 idle cycle between transactions.
REQ-024 iresp_data and dresp_data SHALL hold their last captured value outside RESP.

Reset
REQ-025 On reset=0 at a clock edge: state=IDLE, last_owner=DBUS, all latched fields and data registers cleared.
REQ-026 During reset, creq_valid, iresp_data_ok and dresp_data_ok SHALL be 0 and all data outputs 0.
REQ-027 Reset mid-transaction SHALL abandon it without issuing a response.

Configuration
REQ-028 Macro BUS_ARB_DPRIO_EN: when defined, dbus SHALL always win simultaneous requests and last_owner is unused.
REQ-029 When BUS_ARB_DPRIO_EN is undefined, REQ-012 round-robin SHALL apply.

Verification
REQ-030 Ifetch only: ireq addr=0x8000_0004, memory ready+last after 2 cycles with data 0x1111_2222_3333_4444 -> iresp_data_ok single pulse, iresp_data=0x1111_2222, creq_size=2, is_write=0.
REQ-031 Simultaneous requests after reset, macro off -> ibus granted first, dbus next; macro on -> dbus first.
REQ-032 dbus write: strobe=0x0F, data=0xDEAD_BEEF -> creq_is_write=1, creq_strobe=0x0F; creq fields stable across 4 cycles of cresp_ready=0.
REQ-033 ready and last in the same REQ cycle -> RESP on the next cycle, data_ok 3 cycles after request.
REQ-034 reset=0 asserted in WAIT -> no data_ok issued; IDLE and all outputs zero the next cycle; a stale cresp_last is ignored.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter -- shares one memory-side request port between the core's
// instruction-fetch port (ibus) and data port (dbus).
//
// Ports
//   clk, reset             clock; synchronous active-low reset
//   ireq_valid/addr        fetch request (sampled only in IDLE)
//   iresp_data_ok/data     fetch response: 1-cycle pulse with a 32-bit word
//   dreq_valid/addr/size/strobe/data
//                          data request; strobe == 0 means read
//   dresp_data_ok/data     data response: 1-cycle pulse with 64-bit read data
//   creq_*                 memory request, driven only from latched registers
//   cresp_ready/last/data  memory response: ready = accepted, last = data beat
//
// Build option
//   BUS_ARB_DPRIO_EN       when defined, dbus always wins simultaneous
//                          requests; otherwise ibus/dbus alternate round-robin.
//
// Flow: IDLE -> REQ -> (WAIT) -> RESP -> IDLE. A transaction takes at least
// 3 cycles from request to data_ok, and one IDLE cycle separates transactions.
module bus_arbiter #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [63:0]       dreq_data,
  output logic              dresp_data_ok,
  output logic [63:0]       dresp_data,
  output logic              creq_valid,
  output logic              creq_is_write,
  output logic [ADDR_W-1:0] creq_addr,
  output logic [2:0]        creq_size,
  output logic [7:0]        creq_strobe,
  output logic [63:0]       creq_data,
  input  logic              cresp_ready,
  input  logic              cresp_last,
  input  logic [63:0]       cresp_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [7:0]        strobe_q, strobe_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [31:0]       idata_q, idata_d;
  logic [63:0]       ddata_q, ddata_d;
  logic              grant_i;
  logic              capture;

`ifdef BUS_ARB_DPRIO_EN
  // Fixed priority: ibus only wins when dbus is not asking.
  assign grant_i = ireq_valid & ~dreq_valid;
`else
  // Round-robin: on a tie, the port that did not win last time goes first.
  logic last_owner_q, last_owner_d;

  assign grant_i = ireq_valid & (~dreq_valid | (last_owner_q == OWN_D));

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == S_IDLE && (ireq_valid | dreq_valid))
      last_owner_d = grant_i ? OWN_I : OWN_D;
  end

  always_ff @(posedge clk) begin
    if (!reset) last_owner_q <= OWN_D;
    else        last_owner_q <= last_owner_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    idata_d  = idata_q;
    ddata_d  = ddata_q;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ireq_valid | dreq_valid) begin
          state_d = S_REQ;
          if (grant_i) begin
            // Fetches are always 32-bit reads.
            owner_d  = OWN_I;
            addr_d   = ireq_addr;
            size_d   = 3'b010;
            strobe_d = 8'h00;
            wdata_d  = 64'h0;
          end else begin
            owner_d  = OWN_D;
            addr_d   = dreq_addr;
            size_d   = dreq_size;
            strobe_d = dreq_strobe;
            wdata_d  = dreq_data;
          end
        end
      end
      S_REQ: begin
        if (cresp_ready) begin
          // Zero-wait memory may return the beat together with the accept.
          if (cresp_last) begin
            capture = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cresp_last) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Each port keeps its own data register so a response on one port never
    // disturbs the value held on the other.
    if (capture) begin
      if (owner_q == OWN_I) idata_d = addr_q[2] ? cresp_data[63:32] : cresp_data[31:0];
      else                  ddata_d = cresp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_D;
      addr_q   <= '0;
      size_q   <= 3'b000;
      strobe_q <= 8'h00;
      wdata_q  <= 64'h0;
      idata_q  <= 32'h0;
      ddata_q  <= 64'h0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      idata_q  <= idata_d;
      ddata_q  <= ddata_d;
    end
  end

  assign creq_valid    = (state_q == S_REQ);
  assign creq_is_write = |strobe_q;
  assign creq_addr     = addr_q;
  assign creq_size     = size_q;
  assign creq_strobe   = strobe_q;
  assign creq_data     = wdata_q;

  assign iresp_data_ok = (state_q == S_RESP) && (owner_q == OWN_I);
  assign dresp_data_ok = (state_q == S_RESP) && (owner_q == OWN_D);
  assign iresp_data    = idata_q;
  assign dresp_data    = ddata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter -- cycle vectors for the directed cases, a hand-written
// reset-in-WAIT sequence, then random traffic checked against a
// transaction-level model of the arbiter.
module tb_bus_arbiter;

`ifdef BUS_ARB_DPRIO_EN
  localparam logic DP = 1'b1;
`else
  localparam logic DP = 1'b0;
`endif
  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;

  logic        clk, reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        creq_valid, creq_is_write;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready, cresp_last;
  logic [63:0] cresp_data;

  bus_arbiter #(.ADDR_W(64)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_addr(creq_addr),
    .creq_size(creq_size), .creq_strobe(creq_strobe), .creq_data(creq_data),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic [2:0]  dsz;
    logic [7:0]  dstb;
    logic [63:0] dd;
    logic        rdy, lst;
    logic [63:0] rd;
    logic        e_cv, e_cw;
    logic [2:0]  e_sz;
    logic [7:0]  e_stb;
    logic [63:0] e_ca, e_cd;
    logic        e_iok;
    logic [31:0] e_id;
    logic        e_dok;
    logic [63:0] e_dd;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic iv, input logic [63:0] ia,
    input logic dv, input logic [63:0] da, input logic [2:0] dsz,
    input logic [7:0] dstb, input logic [63:0] dd,
    input logic rdy, input logic lst, input logic [63:0] rd,
    input logic e_cv, input logic e_cw, input logic [2:0] e_sz,
    input logic [7:0] e_stb, input logic [63:0] e_ca, input logic [63:0] e_cd,
    input logic e_iok, input logic [31:0] e_id, input logic e_dok, input logic [63:0] e_dd);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dsz = dsz;
    v.dstb = dstb; v.dd = dd; v.rdy = rdy; v.lst = lst; v.rd = rd;
    v.e_cv = e_cv; v.e_cw = e_cw; v.e_sz = e_sz; v.e_stb = e_stb;
    v.e_ca = e_ca; v.e_cd = e_cd; v.e_iok = e_iok; v.e_id = e_id;
    v.e_dok = e_dok; v.e_dd = e_dd;
    return v;
  endfunction

  task automatic clr_inputs();
    ireq_valid = 1'b0; ireq_addr = 64'h0;
    dreq_valid = 1'b0; dreq_addr = 64'h0; dreq_size = 3'd0;
    dreq_strobe = 8'h00; dreq_data = 64'h0;
    cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = 64'h0;
  endtask

  // Random-phase model state.
  logic        i_pend, d_pend, last_own, own, exp_start, idle_flag, ok_pend;
  logic [63:0] i_addr, d_addr, d_dat, mdata;
  logic [2:0]  d_sz;
  logic [7:0]  d_stb;
  logic [31:0] i_hold;
  logic [63:0] d_hold;
  int          idle_from, ok_at, mp, cnt;

  // Expected memory request for the current owner (1 = ibus).
  task automatic chk_fields(input string nm, input logic o);
    if (o) begin
      chk({nm, ".i_fields"}, {creq_addr, 1'b0, creq_is_write, creq_size, creq_strobe},
          {i_addr, 1'b0, 1'b0, 3'd2, 8'h00});
    end else begin
      chk({nm, ".d_fields"}, {creq_addr, 1'b0, creq_is_write, creq_size, creq_strobe},
          {d_addr, 1'b0, |d_stb, d_sz, d_stb});
      chk({nm, ".d_wdata"}, creq_data, d_dat);
    end
  endtask

  vec_t tv[$];
  localparam logic [63:0] X = 64'h1111_2222_3333_4444;
  localparam logic [63:0] Y = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] Z = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] W = 64'hCAFE_F00D_0000_0001;

  initial begin
    clr_inputs();
    reset = 1'b0;

    // ---- cycle vectors: inputs for the edge, outputs expected after it ----
    // reset
    tv.push_back(mk(L0,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L0,L0,64'h0, L0,L0,3'd0,8'h00,64'h0,64'h0,L0,32'h0,L0,64'h0));
    // ifetch at 0x8000_0004, two cycles of no ready, then ready+last
    tv.push_back(mk(L1,L1,64'h8000_0004,L0,64'h0,3'd0,8'h00,64'h0,L0,L0,64'h0, L1,L0,3'd2,8'h00,64'h8000_0004,64'h0,L0,32'h0,L0,64'h0));
    tv.push_back(mk(L1,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L0,L0,64'h0, L1,L0,3'd2,8'h00,64'h8000_0004,64'h0,L0,32'h0,L0,64'h0));
    tv.push_back(mk(L1,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L0,L0,64'h0, L1,L0,3'd2,8'h00,64'h8000_0004,64'h0,L0,32'h0,L0,64'h0));
    tv.push_back(mk(L1,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L1,L1,X, L0,L0,3'd0,8'h00,64'h0,64'h0,L1,32'h1111_2222,L0,64'h0));
    tv.push_back(mk(L1,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L0,L0,64'h0, L0,L0,3'd0,8'h00,64'h0,64'h0,L0,32'h1111_2222,L0,64'h0));
    // dbus write, then 4 stall cycles while both requesters change their inputs
    tv.push_back(mk(L1,L0,64'h0,L1,64'h1000,3'd3,8'h0F,64'hDEAD_BEEF,L0,L0,64'h0, L1,L1,3'd3,8'h0F,64'h1000,64'hDEAD_BEEF,L0,32'h1111_2222,L0,64'h0));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(L1,L1,64'h40,L1,64'h2000,3'd1,8'hFF,64'h0,L0,L1,64'h0, L1,L1,3'd3,8'h0F,64'h1000,64'hDEAD_BEEF,L0,32'h1111_2222,L0,64'h0));
    tv.push_back(mk(L1,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L1,L0,64'h5555, L0,L0,3'd0,8'h00,64'h0,64'h0,L0,32'h1111_2222,L0,64'h0));
    tv.push_back(mk(L1,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L0,L1,W, L0,L0,3'd0,8'h00,64'h0,64'h0,L0,32'h1111_2222,L1,W));
    tv.push_back(mk(L1,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L0,L0,64'h0, L0,L0,3'd0,8'h00,64'h0,64'h0,L0,32'h1111_2222,L0,W));
    // stray last in IDLE is ignored
    tv.push_back(mk(L1,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L0,L1,64'hFFFF_FFFF_FFFF_FFFF, L0,L0,3'd0,8'h00,64'h0,64'h0,L0,32'h1111_2222,L0,W));
    tv.push_back(mk(L1,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L1,L1,64'hFFFF_FFFF_FFFF_FFFF, L0,L0,3'd0,8'h00,64'h0,64'h0,L0,32'h1111_2222,L0,W));
    // reset, then simultaneous requests; zero-wait winner, one-wait loser
    tv.push_back(mk(L0,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L0,L0,64'h0, L0,L0,3'd0,8'h00,64'h0,64'h0,L0,32'h0,L0,64'h0));
    tv.push_back(mk(L1,L1,64'h8,L1,64'h20,3'd3,8'h00,64'h77,L0,L0,64'h0,
                    L1,L0,DP?3'd3:3'd2,8'h00,DP?64'h20:64'h8,DP?64'h77:64'h0,L0,32'h0,L0,64'h0));
    tv.push_back(mk(L1,L1,64'h8,L1,64'h20,3'd3,8'h00,64'h77,L1,L1,Y,
                    L0,L0,3'd0,8'h00,64'h0,64'h0,!DP,DP?32'h0:32'h89AB_CDEF,DP,DP?Y:64'h0));
    tv.push_back(mk(L1,DP,64'h8,!DP,64'h20,3'd3,8'h00,64'h77,L0,L0,64'h0,
                    L0,L0,3'd0,8'h00,64'h0,64'h0,L0,DP?32'h0:32'h89AB_CDEF,L0,DP?Y:64'h0));
    tv.push_back(mk(L1,DP,64'h8,!DP,64'h20,3'd3,8'h00,64'h77,L0,L0,64'h0,
                    L1,L0,DP?3'd2:3'd3,8'h00,DP?64'h8:64'h20,DP?64'h0:64'h77,L0,DP?32'h0:32'h89AB_CDEF,L0,DP?Y:64'h0));
    tv.push_back(mk(L1,DP,64'h8,!DP,64'h20,3'd3,8'h00,64'h77,L1,L0,64'h0,
                    L0,L0,3'd0,8'h00,64'h0,64'h0,L0,DP?32'h0:32'h89AB_CDEF,L0,DP?Y:64'h0));
    tv.push_back(mk(L1,DP,64'h8,!DP,64'h20,3'd3,8'h00,64'h77,L0,L1,Z,
                    L0,L0,3'd0,8'h00,64'h0,64'h0,DP,DP?32'hCCCC_DDDD:32'h89AB_CDEF,!DP,DP?Y:Z));
    tv.push_back(mk(L1,L0,64'h0,L0,64'h0,3'd0,8'h00,64'h0,L0,L0,64'h0,
                    L0,L0,3'd0,8'h00,64'h0,64'h0,L0,DP?32'hCCCC_DDDD:32'h89AB_CDEF,L0,DP?Y:Z));

    foreach (tv[k]) begin
      reset = tv[k].rst;
      ireq_valid = tv[k].iv; ireq_addr = tv[k].ia;
      dreq_valid = tv[k].dv; dreq_addr = tv[k].da; dreq_size = tv[k].dsz;
      dreq_strobe = tv[k].dstb; dreq_data = tv[k].dd;
      cresp_ready = tv[k].rdy; cresp_last = tv[k].lst; cresp_data = tv[k].rd;
      step();
      chk($sformatf("vec%0d.ok", k), 64'({creq_valid, iresp_data_ok, dresp_data_ok}),
          64'({tv[k].e_cv, tv[k].e_iok, tv[k].e_dok}));
      chk($sformatf("vec%0d.idata", k), 64'(iresp_data), 64'(tv[k].e_id));
      chk($sformatf("vec%0d.ddata", k), dresp_data, tv[k].e_dd);
      if (tv[k].e_cv || !tv[k].rst) begin
        chk($sformatf("vec%0d.cfields", k), {creq_addr, 1'b0, creq_is_write, creq_size, creq_strobe},
            {tv[k].e_ca, 1'b0, tv[k].e_cw, tv[k].e_sz, tv[k].e_stb});
        chk($sformatf("vec%0d.cdata", k), creq_data, tv[k].e_cd);
      end
    end

    // ---- reset while in WAIT, with memory asserting last at that edge ----
    clr_inputs();
    ireq_valid = 1'b1; ireq_addr = 64'h10;
    step();
    chk("rstw.req", 64'(creq_valid), 64'(1'b1));
    ireq_valid = 1'b0; cresp_ready = 1'b1;
    step();
    chk("rstw.wait", 64'(creq_valid), 64'(1'b0));
    reset = 1'b0; cresp_ready = 1'b0; cresp_last = 1'b1; cresp_data = 64'h9999_8888_7777_6666;
    step();
    chk("rstw.ok", 64'({creq_valid, iresp_data_ok, dresp_data_ok}), 64'(3'b000));
    chk("rstw.zero", {creq_addr, 1'b0, creq_is_write, creq_size, creq_strobe}, 76'h0);
    chk("rstw.zdata", creq_data | dresp_data | 64'(iresp_data), 64'h0);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("rstw.stale%0d", k), 64'({creq_valid, iresp_data_ok, dresp_data_ok}), 64'(3'b000));
      chk($sformatf("rstw.sdata%0d", k), 64'(iresp_data), 64'h0);
      cresp_last = 1'b0;
    end

    // ---- random traffic against a transaction-level model ----
    clr_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
    i_pend = 0; d_pend = 0; last_own = 0; own = 0; exp_start = 0; ok_pend = 0;
    idle_flag = 1; idle_from = 0; ok_at = 0; mp = 0; cnt = 0;
    i_hold = 32'h0; d_hold = 64'h0; mdata = 64'h0;
    i_addr = 64'h0; d_addr = 64'h0; d_dat = 64'h0; d_sz = 3'd0; d_stb = 8'h00;
    for (int t = 0; t < 3000; t++) begin
      // response pulses
      if (ok_pend && ok_at == t) begin
        if (own) i_hold = i_addr[2] ? mdata[63:32] : mdata[31:0];
        else     d_hold = mdata;
        chk($sformatf("rnd%0d.ok", t), 64'({iresp_data_ok, dresp_data_ok}), 64'({own, !own}));
        if (own) i_pend = 0; else d_pend = 0;
        ok_pend = 0; idle_flag = 1; idle_from = t + 1;
      end else begin
        chk($sformatf("rnd%0d.nok", t), 64'({iresp_data_ok, dresp_data_ok}), 64'(2'b00));
      end
      chk($sformatf("rnd%0d.hold", t), {iresp_data, dresp_data}, {i_hold, d_hold});

      // memory request side
      if (exp_start) begin
        chk($sformatf("rnd%0d.grant", t), 64'(creq_valid), 64'(1'b1));
        chk_fields($sformatf("rnd%0d", t), own);
        exp_start = 0; mp = 1; cnt = int'($urandom_range(0, 3));
      end else if (mp == 1) begin
        chk($sformatf("rnd%0d.hold_req", t), 64'(creq_valid), 64'(1'b1));
        chk_fields($sformatf("rnd%0d.stable", t), own);
      end else begin
        chk($sformatf("rnd%0d.noreq", t), 64'(creq_valid), 64'(1'b0));
      end

      // new requests from the core
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_addr = {$urandom, $urandom};
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_addr = {$urandom, $urandom}; d_sz = 3'($urandom);
        d_stb = $urandom_range(0, 1) ? 8'($urandom) : 8'h00; d_dat = {$urandom, $urandom};
      end
      ireq_valid = i_pend; ireq_addr = i_addr;
      dreq_valid = d_pend; dreq_addr = d_addr; dreq_size = d_sz;
      dreq_strobe = d_stb; dreq_data = d_dat;

      // arbitration decision for a grant sampled at this edge
      if (idle_flag && t >= idle_from && (i_pend || d_pend)) begin
        if (i_pend && d_pend) own = DP ? 1'b0 : !last_own;
        else                  own = i_pend;
        last_own = own; exp_start = 1; idle_flag = 0;
      end

      // memory responder
      cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = {$urandom, $urandom};
      if (mp == 1) begin
        if (cnt == 0) begin
          cresp_ready = 1'b1;
          cresp_last = 1'($urandom_range(0, 1));
          if (cresp_last) begin
            mdata = cresp_data; ok_pend = 1; ok_at = t + 1; mp = 0;
          end else begin
            mp = 2; cnt = int'($urandom_range(0, 3));
          end
        end else cnt--;
      end else if (mp == 2) begin
        cresp_ready = 1'($urandom_range(0, 1));
        if (cnt == 0) begin
          cresp_last = 1'b1; mdata = cresp_data; ok_pend = 1; ok_at = t + 1; mp = 0;
        end else cnt--;
      end else begin
        cresp_last = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
